jtsdram_bank_check: RTL and testbench

Parametrised SDRAM bank test engine: sweeps one bank's full address range, optionally writing a pattern first, then reads every word back and checks it against the expected pattern. It sits between the test sequencer and one SDRAM controller slot, issuing one request at a time. New requests are held off during vertical blank so the video frame is not disturbed. It reports a sticky failure flag, a saturating error count and the first failing address.

---
 rtl/jtsdram_bank_check.sv | 133 +++++++++++++
 tb/tb_jtsdram_bank_check.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtsdram_bank_check.sv
// rtl/jtsdram_bank_check.sv - SDRAM bank sweep engine: optional pattern write pass, then read-back compare
module jtsdram_bank_check #(
    parameter int AW   = 22,
    parameter int DW   = 32,
    parameter int ERRW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            LVBL,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [15:0]     data_ref,
    output logic [AW-1:0]   addr,
    output logic            rd,
    output logic            wr,
    output logic [DW-1:0]   din,
    input  logic            ack,
    input  logic            rdy,
    input  logic [DW-1:0]   data_read,
    output logic            busy,
    output logic            done,
    output logic            bad,
    output logic [ERRW-1:0] err_cnt,
    output logic [AW-1:0]   first_bad
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t        state;
    logic [15:0]   ref_r;
    logic          mbit0;
    logic          pend;
    logic          wait_rdy;
    logic          last;
    logic          miss;
    logic          nx_write;
    logic [AW-1:0] addr_nx;

    // Expected word at address a: the 16-bit seed, optionally mixed with the low address bits,
    // replicated across the data bus
    function automatic logic [DW-1:0] pat(input logic [15:0] r, input logic m, input logic [AW-1:0] a);
        logic [15:0] w;
        w = r ^ (m ? 16'(a) : 16'd0);
        return {(DW/16){w}};
    endfunction

    // Where the sweep goes once the current request completes, and whether the read data matches
    always_comb begin
        last     = &addr;
        addr_nx  = last ? '0 : addr + AW'(1);
        nx_write = (state == WRITE) && !last;
        miss     = data_read != pat(ref_r, mbit0, addr);
    end

    // Sweep FSM: one outstanding request, completion on rdy, new requests held off while LVBL is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            din       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bad       <= 1'b0;
            err_cnt   <= '0;
            first_bad <= '0;
            ref_r     <= '0;
            mbit0     <= 1'b0;
            pend      <= 1'b0;
            wait_rdy  <= 1'b0;
        end else if (start) begin
            // The first request is issued regardless of blanking
            state     <= mode[1] ? WRITE : READ;
            addr      <= '0;
            bad       <= 1'b0;
            err_cnt   <= '0;
            first_bad <= '0;
            done      <= 1'b0;
            pend      <= 1'b0;
            wait_rdy  <= 1'b0;
            busy      <= 1'b1;
            ref_r     <= data_ref;
            mbit0     <= mode[0];
            rd        <= !mode[1];
            wr        <= mode[1];
            if (mode[1]) din <= pat(data_ref, mode[0], '0);
        end else if (state == WRITE || state == READ) begin
            if (rd || wr) begin
                // A simultaneous rdy belongs to no accepted request yet, so only ack matters here
                if (ack) begin
                    rd       <= 1'b0;
                    wr       <= 1'b0;
                    wait_rdy <= 1'b1;
                end
            end else if (pend) begin
                if (LVBL) begin
                    pend <= 1'b0;
                    if (state == WRITE) begin
                        wr  <= 1'b1;
                        din <= pat(ref_r, mbit0, addr);
                    end else begin
                        rd <= 1'b1;
                    end
                end
            end else if (wait_rdy && rdy) begin
                wait_rdy <= 1'b0;
                if (state == READ && miss) begin
                    bad <= 1'b1;
                    if (err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
                    if (!bad) first_bad <= addr;
                end
                if (state == READ && last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    addr <= addr_nx;
                    if (last) state <= READ;
                    if (!LVBL) begin
                        pend <= 1'b1;
                    end else if (nx_write) begin
                        wr  <= 1'b1;
                        din <= pat(ref_r, mbit0, addr_nx);
                    end else begin
                        rd <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jtsdram_bank_check.sv
// tb/tb_jtsdram_bank_check.sv - directed checks of the bank sweep engine against a small SDRAM slot model
module tb_jtsdram_bank_check;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int ERRW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            LVBL = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [15:0]     data_ref = 16'h0000;
    logic [AW-1:0]   addr;
    logic            rd;
    logic            wr;
    logic [DW-1:0]   din;
    logic            ack = 1'b0;
    logic            rdy = 1'b0;
    logic [DW-1:0]   data_read = '0;
    logic            busy;
    logic            done;
    logic            bad;
    logic [ERRW-1:0] err_cnt;
    logic [AW-1:0]   first_bad;

    int checks = 0;
    int errors = 0;

    logic        use_fill = 1'b0;
    logic [31:0] fill = 32'h0;
    logic [15:0] corrupt = 16'h0;

    logic [31:0] mem [16];
    int          mph = 0;
    logic        l_wr = 1'b0;
    logic [3:0]  l_addr = 4'h0;
    bit          q_wr [$];
    logic [3:0]  q_addr [$];
    logic [31:0] q_din [$];

    int base;
    int viol;

    jtsdram_bank_check #(.AW(AW), .DW(DW), .ERRW(ERRW)) dut (
        .clk       (clk),
        .rst       (rst),
        .LVBL      (LVBL),
        .start     (start),
        .mode      (mode),
        .data_ref  (data_ref),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .din       (din),
        .ack       (ack),
        .rdy       (rdy),
        .data_read (data_read),
        .busy      (busy),
        .done      (done),
        .bad       (bad),
        .err_cnt   (err_cnt),
        .first_bad (first_bad)
    );

    always #5 clk = ~clk;

    // Controller slot model: ack one cycle after a request is seen, rdy two cycles after ack
    always @(negedge clk) begin
        ack = 1'b0;
        rdy = 1'b0;
        if (rst) begin
            mph = 0;
        end else begin
            case (mph)
                0: if (rd || wr) mph = 1;
                1: begin
                    if (rd || wr) begin
                        ack    = 1'b1;
                        l_wr   = wr;
                        l_addr = addr;
                        q_wr.push_back(wr);
                        q_addr.push_back(addr);
                        q_din.push_back(din);
                        if (wr) mem[addr] = din;
                        mph = 2;
                    end else begin
                        mph = 0;
                    end
                end
                2: mph = 3;
                default: begin
                    rdy = 1'b1;
                    if (!l_wr)
                        data_read = (use_fill ? fill : mem[l_addr]) ^ (corrupt[l_addr] ? 32'h1 : 32'h0);
                    mph = 0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_addr"}, 32'(addr), 32'h0);
        check({pfx, "_rd"}, 32'(rd), 32'h0);
        check({pfx, "_wr"}, 32'(wr), 32'h0);
        check({pfx, "_din"}, din, 32'h0);
        check({pfx, "_busy"}, 32'(busy), 32'h0);
        check({pfx, "_done"}, 32'(done), 32'h0);
        check({pfx, "_bad"}, 32'(bad), 32'h0);
        check({pfx, "_err_cnt"}, 32'(err_cnt), 32'h0);
        check({pfx, "_first_bad"}, 32'(first_bad), 32'h0);
    endtask

    // Called at a falling edge; start is seen by the DUT at the next rising edge
    task automatic pulse_start(input logic [1:0] m, input logic [15:0] r);
        mode     = m;
        data_ref = r;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 1000 && done !== 1'b1; n++) @(negedge clk);
        check(tag, 32'(done), 32'h1);
    endtask

    task automatic wait_req(input logic [3:0] a, input logic want_wr, input string tag);
        for (int n = 0; n < 1000 && !(addr === a && (want_wr ? wr : rd) === 1'b1); n++) @(negedge clk);
        check(tag, {31'd0, (addr === a && (want_wr ? wr : rd) === 1'b1)}, 32'h1);
    endtask

    function automatic bit log_ok(input int b, input int off, input int n, input bit kind);
        if (q_wr.size() < b + off + n) return 1'b0;
        for (int i = 0; i < n; i++)
            if (q_wr[b+off+i] != kind || q_addr[b+off+i] !== 4'(i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit din_ok(input int b, input logic [15:0] r);
        logic [15:0] w;
        if (q_din.size() < b + 16) return 1'b0;
        for (int i = 0; i < 16; i++) begin
            w = r ^ 16'(i);
            if (q_din[b+i] !== {w, w}) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Read-only sweep, constant pattern; first request must not wait for LVBL
        LVBL     = 1'b0;
        use_fill = 1'b1;
        fill     = 32'hA55AA55A;
        corrupt  = 16'h0;
        base     = q_wr.size();
        pulse_start(2'b00, 16'hA55A);
        check("t1_first_rd_ungated", 32'(rd), 32'h1);
        check("t1_first_wr", 32'(wr), 32'h0);
        check("t1_busy", 32'(busy), 32'h1);
        LVBL = 1'b1;
        wait_done("t1_done");
        check("t1_busy_end", 32'(busy), 32'h0);
        check("t1_bad", 32'(bad), 32'h0);
        check("t1_err_cnt", 32'(err_cnt), 32'h0);
        check("t1_req_count", 32'(q_wr.size() - base), 32'd16);
        check("t1_read_seq", 32'(log_ok(base, 0, 16, 1'b0)), 32'h1);

        // Write then read, address-mixed pattern
        use_fill = 1'b0;
        base     = q_wr.size();
        pulse_start(2'b11, 16'h1234);
        wait_done("t2_done");
        check("t2_req_count", 32'(q_wr.size() - base), 32'd32);
        check("t2_write_seq", 32'(log_ok(base, 0, 16, 1'b1)), 32'h1);
        check("t2_read_seq", 32'(log_ok(base, 16, 16, 1'b0)), 32'h1);
        check("t2_din_addr3", q_din[base+3], 32'h12371237);
        check("t2_din_all", 32'(din_ok(base, 16'h1234)), 32'h1);
        check("t2_bad", 32'(bad), 32'h0);
        check("t2_err_cnt", 32'(err_cnt), 32'h0);

        // Read-only, corrupted words at 5 and 9
        corrupt = 16'h0220;
        pulse_start(2'b01, 16'h1234);
        wait_done("t3_done");
        check("t3_bad", 32'(bad), 32'h1);
        check("t3_err_cnt", 32'(err_cnt), 32'd2);
        check("t3_first_bad", 32'(first_bad), 32'd5);

        // Vertical blank around the completion of address 7
        corrupt = 16'h0;
        pulse_start(2'b01, 16'h1234);
        wait_req(4'd7, 1'b0, "t4_reach_addr7");
        LVBL = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd === 1'b1 && addr !== 4'd7) viol++;
        end
        check("t4_no_rd_in_vblank", 32'(viol), 32'h0);
        check("t4_addr_held", 32'(addr), 32'd8);
        check("t4_rd_low_at_lvbl", 32'(rd), 32'h0);
        LVBL = 1'b1;
        @(negedge clk);
        check("t4_rd8_rise", 32'(rd), 32'h1);
        wait_done("t4_done");
        check("t4_bad", 32'(bad), 32'h0);

        // Every read wrong: 2-bit counter saturates
        corrupt = 16'hFFFF;
        pulse_start(2'b01, 16'h1234);
        wait_done("t5_done");
        check("t5_err_cnt_sat", 32'(err_cnt), 32'd3);
        check("t5_first_bad", 32'(first_bad), 32'd0);
        check("t5_bad", 32'(bad), 32'h1);

        // Restart mid-read, then asynchronous reset during the write pass
        corrupt = 16'h0004;
        pulse_start(2'b01, 16'h1234);
        wait_req(4'd6, 1'b0, "t6_reach_addr6");
        check("t6_pre_bad", 32'(bad), 32'h1);
        check("t6_pre_err_cnt", 32'(err_cnt), 32'd1);
        check("t6_pre_first_bad", 32'(first_bad), 32'd2);
        pulse_start(2'b11, 16'h1234);
        corrupt = 16'h0;
        check("t6_addr", 32'(addr), 32'h0);
        check("t6_bad", 32'(bad), 32'h0);
        check("t6_err_cnt", 32'(err_cnt), 32'h0);
        check("t6_first_bad", 32'(first_bad), 32'h0);
        check("t6_done", 32'(done), 32'h0);
        check("t6_busy", 32'(busy), 32'h1);
        check("t6_wr", 32'(wr), 32'h1);
        check("t6_rd", 32'(rd), 32'h0);
        check("t6_din", din, 32'h12341234);
        wait_req(4'd3, 1'b1, "t6_reach_write3");
        #2 rst = 1'b1;
        #1 check_reset("t6_async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_after_rst", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
